// File: rtl/framebuffer_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the double-buffered LED frame store.
package framebuffer_pkg;

    localparam int c_default_ch_per_board = 32;
    localparam int c_default_bpc          = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_CLEAR   = 2'd2
    } fb_state_e;

    // Two pages of 2^addr_w words each.
    function automatic int fb_depth(input int addr_w);
        return 2 ** (addr_w + 1);
    endfunction

endpackage

// File: rtl/framebuffer_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, contents never reset.
module framebuffer_dpram #(
    parameter int c_aw    = 11,
    parameter int c_dw    = 12,
    parameter int c_depth = 2 ** c_aw
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [c_aw-1:0] i_waddr,
    input  logic [c_dw-1:0] i_wdata,
    input  logic            i_re,
    input  logic [c_aw-1:0] i_raddr,
    output logic [c_dw-1:0] o_rdata
);

    logic [c_dw-1:0] mem_r [c_depth];
    logic [c_dw-1:0] rdata_r;

    // Write port and enable-gated registered read; the read register holds when idle.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_r[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_r <= mem_r[i_raddr];
        end
    end

    assign o_rdata = rdata_r;

endmodule

// File: rtl/framebuffer_dbuf.sv
// Double-buffered frame store: writer fills the back page, shifter reads the front page, swap at frame end.
// Optional macro FRAMEBUFFER_CLEAR_EN adds i_clear/o_busy and a back-page clear walker.
module framebuffer_dbuf
    import framebuffer_pkg::*;
#(
    parameter int c_ledboards    = 30,
    parameter int c_ch_per_board = c_default_ch_per_board,
    parameter int c_channels     = c_ledboards * c_ch_per_board,
    parameter int c_addr_w       = $clog2(c_channels),
    parameter int c_bpc          = c_default_bpc
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wen,
    input  logic [c_addr_w-1:0] i_waddr,
    input  logic [c_bpc-1:0]    i_wdata,
    input  logic                i_ren,
    input  logic [c_addr_w-1:0] i_raddr,
    output logic [c_bpc-1:0]    o_rdata,
    output logic                o_rvalid,
    input  logic                i_swap,
    input  logic                i_frame_done,
    output logic                o_swap_pending,
    output logic                o_front_page
`ifdef FRAMEBUFFER_CLEAR_EN
    ,
    input  logic                i_clear,
    output logic                o_busy
`endif
);

    localparam int                  c_ram_aw = c_addr_w + 1;
    localparam int                  c_depth  = fb_depth(c_addr_w);
    localparam logic [c_addr_w:0]   c_lim    = (c_addr_w + 1)'(c_channels);
    localparam logic [c_addr_w-1:0] c_last   = c_addr_w'(c_channels - 1);

    fb_state_e             state_r, state_nxt_s;
    logic                  front_r, front_nxt_s;
    logic                  pending_r, pending_nxt_s;
    logic                  rvalid_r;
    logic                  data_ok_r;
    logic                  wr_in_range_s, rd_in_range_s;
    logic                  ram_we_s;
    logic [c_ram_aw-1:0]   ram_waddr_s;
    logic [c_bpc-1:0]      ram_wdata_s;
    logic [c_bpc-1:0]      ram_rdata_s;
    logic [c_addr_w-1:0]   clr_cnt_r, clr_cnt_nxt_s;

    assign wr_in_range_s = ({1'b0, i_waddr} < c_lim);
    assign rd_in_range_s = ({1'b0, i_raddr} < c_lim);

    // Swap FSM: front toggles only on a frame boundary; clear walker owns the back page while active.
    always_comb begin
        state_nxt_s   = state_r;
        front_nxt_s   = front_r;
        pending_nxt_s = pending_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (i_swap && i_frame_done) begin
                    front_nxt_s = ~front_r;
                end else if (i_swap) begin
                    state_nxt_s   = ST_PENDING;
                    pending_nxt_s = 1'b1;
`ifdef FRAMEBUFFER_CLEAR_EN
                end else if (i_clear) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_cnt_nxt_s = '0;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (i_frame_done) begin
                    front_nxt_s   = ~front_r;
                    pending_nxt_s = 1'b0;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PENDING;
                end
            end
`ifdef FRAMEBUFFER_CLEAR_EN
            ST_CLEAR: begin
                pending_nxt_s = pending_r | i_swap;
                if (clr_cnt_r == c_last) begin
                    state_nxt_s = (pending_r | i_swap) ? ST_PENDING : ST_IDLE;
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + 1'b1;
                end
            end
`endif
            default: begin
                state_nxt_s   = ST_IDLE;
                pending_nxt_s = 1'b0;
            end
        endcase
    end

    // Back-page write port mux: host writes, or zeros from the clear walker.
    always_comb begin
        ram_we_s    = i_wen && wr_in_range_s;
        ram_waddr_s = {~front_r, i_waddr};
        ram_wdata_s = i_wdata;
`ifdef FRAMEBUFFER_CLEAR_EN
        if (state_r == ST_CLEAR) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = {~front_r, clr_cnt_r};
            ram_wdata_s = '0;
        end else begin
            ram_we_s    = i_wen && wr_in_range_s;
        end
`endif
    end

    // Control state; reset cancels any pending swap and returns to page 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            front_r   <= 1'b0;
            pending_r <= 1'b0;
            clr_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            front_r   <= front_nxt_s;
            pending_r <= pending_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
        end
    end

    // Read qualifiers; data_ok_r masks RAM output after reset and for out-of-range reads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rvalid_r  <= 1'b0;
            data_ok_r <= 1'b0;
        end else begin
            rvalid_r <= i_ren;
            if (i_ren) begin
                data_ok_r <= rd_in_range_s;
            end
        end
    end

    framebuffer_dpram #(
        .c_aw    (c_ram_aw),
        .c_dw    (c_bpc),
        .c_depth (c_depth)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we_s),
        .i_waddr (ram_waddr_s),
        .i_wdata (ram_wdata_s),
        .i_re    (i_ren),
        .i_raddr ({front_r, i_raddr}),
        .o_rdata (ram_rdata_s)
    );

    assign o_rdata        = data_ok_r ? ram_rdata_s : '0;
    assign o_rvalid       = rvalid_r;
    assign o_swap_pending = pending_r;
    assign o_front_page   = front_r;
`ifdef FRAMEBUFFER_CLEAR_EN
    assign o_busy         = (state_r == ST_CLEAR);
`endif

endmodule

// File: tb/tb_framebuffer_dbuf.sv
// Directed bench for framebuffer_dbuf with a page-level reference model checked every cycle.
module tb_framebuffer_dbuf;

    localparam int CH = 960;
    localparam int AW = 10;
    localparam int DW = 12;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_wen = 1'b0;
    logic [AW-1:0] i_waddr = '0;
    logic [DW-1:0] i_wdata = '0;
    logic          i_ren = 1'b0;
    logic [AW-1:0] i_raddr = '0;
    logic [DW-1:0] o_rdata;
    logic          o_rvalid;
    logic          i_swap = 1'b0;
    logic          i_frame_done = 1'b0;
    logic          o_swap_pending;
    logic          o_front_page;
`ifdef FRAMEBUFFER_CLEAR_EN
    logic          i_clear = 1'b0;
    logic          o_busy;
`endif

    framebuffer_dbuf dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_wen          (i_wen),
        .i_waddr        (i_waddr),
        .i_wdata        (i_wdata),
        .i_ren          (i_ren),
        .i_raddr        (i_raddr),
        .o_rdata        (o_rdata),
        .o_rvalid       (o_rvalid),
        .i_swap         (i_swap),
        .i_frame_done   (i_frame_done),
        .o_swap_pending (o_swap_pending),
        .o_front_page   (o_front_page)
`ifdef FRAMEBUFFER_CLEAR_EN
        ,
        .i_clear        (i_clear),
        .o_busy         (o_busy)
`endif
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two page arrays, a front index and a pending flag.
    logic [DW-1:0] m_mem   [2][CH];
    bit            m_known [2][CH];
    int m_front = 0, m_pend = 0, m_rvalid = 0, m_rdata = 0, m_rknown = 1, m_clear_left = 0, m_fr = 0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_front = 0; m_pend = 0; m_rvalid = 0; m_rdata = 0; m_rknown = 1; m_clear_left = 0;
        end else begin
            m_fr = m_front;
            m_rvalid = i_ren ? 1 : 0;
            if (i_ren) begin
                if (int'(i_raddr) < CH) begin
                    m_rknown = m_known[m_fr][i_raddr] ? 1 : 0;
                    m_rdata  = int'(m_mem[m_fr][i_raddr]);
                end else begin
                    m_rknown = 1; m_rdata = 0;
                end
            end
            if (m_clear_left > 0) begin
                if (i_swap) m_pend = 1;
                m_clear_left--;
                if (m_clear_left == 0)
                    for (int k = 0; k < CH; k++) begin m_mem[1-m_fr][k] = '0; m_known[1-m_fr][k] = 1'b1; end
            end else begin
                if (i_wen && int'(i_waddr) < CH) begin
                    m_mem[1-m_fr][i_waddr] = i_wdata; m_known[1-m_fr][i_waddr] = 1'b1;
                end
                if (m_pend != 0) begin
                    if (i_frame_done) begin m_front = 1 - m_front; m_pend = 0; end
                end else if (i_swap) begin
                    if (i_frame_done) m_front = 1 - m_front;
                    else m_pend = 1;
                end
`ifdef FRAMEBUFFER_CLEAR_EN
                else if (i_clear) m_clear_left = CH;
`endif
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge i_clk) begin
        if (i_rst_n && chk_en) begin
            chk("cyc_front", int'(o_front_page), m_front);
            chk("cyc_pending", int'(o_swap_pending), m_pend);
            chk("cyc_rvalid", int'(o_rvalid), m_rvalid);
            if (m_rknown != 0) chk("cyc_rdata", int'(o_rdata), m_rdata);
`ifdef FRAMEBUFFER_CLEAR_EN
            chk("cyc_busy", int'(o_busy), (m_clear_left > 0) ? 1 : 0);
`endif
        end
    end

    task automatic step(input bit wen, input int waddr, input int wdata,
                        input bit ren, input int raddr, input bit sw, input bit fd);
        i_wen = wen; i_waddr = AW'(waddr); i_wdata = DW'(wdata);
        i_ren = ren; i_raddr = AW'(raddr); i_swap = sw; i_frame_done = fd;
        @(posedge i_clk); #2;
        i_wen = 1'b0; i_ren = 1'b0; i_swap = 1'b0; i_frame_done = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #2;
        chk("rst_front", int'(o_front_page), 0);
        chk("rst_pending", int'(o_swap_pending), 0);
        chk("rst_rvalid", int'(o_rvalid), 0);
        chk("rst_rdata", int'(o_rdata), 0);
        i_rst_n = 1'b1;
        chk_en = 1'b1;

        // Read after reset: one-cycle valid pulse.
        step(1'b0, 0, 0, 1'b1, 5, 1'b0, 1'b0);
        chk("rd5_rvalid", int'(o_rvalid), 1);
        idle();
        chk("rvalid_drop", int'(o_rvalid), 0);

        // Write, request swap, hold pending three cycles, commit on frame_done.
        step(1'b1, 7, 'hABC, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0);
        chk("pend_c1", int'(o_swap_pending), 1);
        idle();
        chk("pend_c2", int'(o_swap_pending), 1);
        idle();
        chk("pend_c3", int'(o_swap_pending), 1);
        chk("front_before", int'(o_front_page), 0);
        step(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
        chk("pend_cleared", int'(o_swap_pending), 0);
        chk("front_after", int'(o_front_page), 1);
        step(1'b0, 0, 0, 1'b1, 7, 1'b0, 1'b0);
        chk("rd7", int'(o_rdata), 'hABC);

        // Same-edge swap+frame_done with write and read on the commit edge.
        step(1'b1, 0, 'h123, 1'b1, 7, 1'b1, 1'b1);
        chk("commit_rd_old_front", int'(o_rdata), 'hABC);
        chk("front_toggle", int'(o_front_page), 0);
        step(1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b0);
        chk("rd0", int'(o_rdata), 'h123);

        // Stray frame_done, repeated swap while pending, write while pending.
        step(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
        chk("fd_no_effect", int'(o_front_page), 0);
        step(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 3, 'h777, 1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
        chk("single_toggle", int'(o_front_page), 1);
        step(1'b0, 0, 0, 1'b1, 3, 1'b0, 1'b0);
        chk("rd3_pending_write", int'(o_rdata), 'h777);

        // Out-of-range write ignored, out-of-range read returns 0.
        step(1'b1, 959, 'h5A5, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 960, 'hFFF, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 0, 1'b1, 960, 1'b0, 1'b0);
        chk("rd960_valid", int'(o_rvalid), 1);
        chk("rd960_zero", int'(o_rdata), 0);
        step(1'b0, 0, 0, 1'b1, 959, 1'b0, 1'b0);
        chk("rd959", int'(o_rdata), 'h5A5);
        idle();
        chk("rdata_hold", int'(o_rdata), 'h5A5);

        // Async reset in the middle of a pending swap.
        step(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 0, 1'b1, 959, 1'b1, 1'b0);
        chk("pre_rst_pending", int'(o_swap_pending), 1);
        chk("pre_rst_front", int'(o_front_page), 1);
        #1 i_rst_n = 1'b0;
        #1;
        chk("arst_pending", int'(o_swap_pending), 0);
        chk("arst_front", int'(o_front_page), 0);
        chk("arst_rvalid", int'(o_rvalid), 0);
        chk("arst_rdata", int'(o_rdata), 0);
        @(posedge i_clk); #2;
        i_rst_n = 1'b1;
        step(1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b0);
        chk("mem_kept_rd0", int'(o_rdata), 'h123);

`ifdef FRAMEBUFFER_CLEAR_EN
        begin
            int busy_cnt;
            int nonzero;
            busy_cnt = 0;
            nonzero = 0;
            for (int a = 0; a < CH; a++) step(1'b1, a, 'hFFF, 1'b0, 0, 1'b0, 1'b0);
            i_clear = 1'b1;
            idle();
            i_clear = 1'b0;
            for (int i = 0; i < 2000 && o_busy; i++) begin
                busy_cnt++;
                step(1'b1, 5, 'h111, 1'b0, 0, (i == 0), 1'b1);
            end
            chk("busy_cycles", busy_cnt, 960);
            chk("clear_pending", int'(o_swap_pending), 1);
            step(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
            chk("clear_swap_front", int'(o_front_page), 1);
            for (int a = 0; a < CH; a++) begin
                step(1'b0, 0, 0, 1'b1, a, 1'b0, 1'b0);
                if (o_rdata != '0) nonzero++;
            end
            chk("clear_all_zero", nonzero, 0);
        end
`endif

        idle();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
